pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_if.sv | 25 ++
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if -- hazard/stall control bundle between the pipeline and pipe_ctrl.
//   Pipeline -> controller: id_stallreq_i, ex_mc_start_i, ex_mc_cycles_i[5:0],
//                           ex_mc_done_i, flush_i
//   Controller -> pipeline: stall_o[5:0] (bit0 PC .. bit5 WB), flush_o, busy_o
// Modports: master = pipeline side, slave = pipe_ctrl.
interface pipe_ctrl_if;
  logic       id_stallreq_i;
  logic       ex_mc_start_i;
  logic [5:0] ex_mc_cycles_i;
  logic       ex_mc_done_i;
  logic       flush_i;
  logic [5:0] stall_o;
  logic       flush_o;
  logic       busy_o;

  modport master (
    output id_stallreq_i, ex_mc_start_i, ex_mc_cycles_i, ex_mc_done_i, flush_i,
    input  stall_o, flush_o, busy_o
  );

  modport slave (
    input  id_stallreq_i, ex_mc_start_i, ex_mc_cycles_i, ex_mc_done_i, flush_i,
    output stall_o, flush_o, busy_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline stall/flush controller.
//   Arbitrates flush (highest), multi-cycle execute stalls, and load-use
//   stalls (lowest). All outputs are combinational from state, the down
//   counter and the current inputs, so they act in the same cycle.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset; forces outputs low while high
//   pif          pipe_ctrl_if.slave (hazard inputs, stall_o/flush_o/busy_o)
//   stall_cnt_o  32-bit count of stalled cycles (only with PIPE_PERF_CNT_EN)
// Optional feature macro: PIPE_PERF_CNT_EN enables the stall cycle counter.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cnt_o,
`endif
  pipe_ctrl_if.slave  pif
);

  typedef enum logic {
    IDLE    = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  // PC/IF/ID/EX frozen for a multi-cycle op; PC/IF/ID only for load-use
  // (EX receives a bubble).
  localparam logic [5:0] STALL_MC = 6'b001111;
  localparam logic [5:0] STALL_LU = 6'b000111;

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] stall;
  logic       flush;
  logic       busy;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = '0;
    flush   = 1'b0;
    busy    = 1'b0;

    if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      busy = (state_q == MC_WAIT);
      if (pif.flush_i) begin
        // Flush wins over everything and aborts any running op.
        flush   = 1'b1;
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (pif.ex_mc_start_i && (pif.ex_mc_cycles_i != '0)) begin
              // The start cycle itself is the first stalled cycle.
              stall = STALL_MC;
              if (pif.ex_mc_cycles_i != 6'd1) begin
                cnt_d   = pif.ex_mc_cycles_i - 6'd1;
                state_d = MC_WAIT;
              end
            end else if (pif.id_stallreq_i) begin
              stall = STALL_LU;
            end
          end
          MC_WAIT: begin
            // Load-use requests and new starts are masked here.
            if (pif.ex_mc_done_i) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              stall = STALL_MC;
              cnt_d = cnt_q - 6'd1;
              // cnt of 1 marks the final stalled cycle; <=1 also recovers
              // from an impossible zero count.
              if (cnt_q <= 6'd1) begin
                state_d = IDLE;
                cnt_d   = '0;
              end
            end
          end
          default: begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pif.stall_o = stall;
  assign pif.flush_o = flush;
  assign pif.busy_o  = busy;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // stall is already zero during reset; wraps naturally at 32 bits and is
  // deliberately unaffected by flush.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall != '0) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- scoreboard bench for pipe_ctrl.
//   Each stimulus row pushes its expected outputs into a queue; a monitor on
//   the falling edge pops and compares them. With PIPE_PERF_CNT_EN defined,
//   the stall counter is also checked against a running reference count.
module tb_pipe_ctrl;

  logic clk;
  logic rst;
  pipe_ctrl_if bus ();

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  pipe_ctrl dut (
    .clk         (clk),
    .rst         (rst),
`ifdef PIPE_PERF_CNT_EN
    .stall_cnt_o (stall_cnt_o),
`endif
    .pif         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       rst;
    logic [5:0] stall;
    logic       flush;
    logic       busy;
    logic       preload;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        fin   = 1'b0;
  logic [31:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus plus its expected outputs.
  task automatic step(input string tag, input logic r, input logic sr,
                      input logic st, input logic [5:0] cyc, input logic dn,
                      input logic fl, input logic [5:0] es, input logic ef,
                      input logic eb, input logic pre = 1'b0);
    exp_t e;
    rst                = r;
    bus.id_stallreq_i  = sr;
    bus.ex_mc_start_i  = st;
    bus.ex_mc_cycles_i = cyc;
    bus.ex_mc_done_i   = dn;
    bus.flush_i        = fl;
    e.tag = tag; e.rst = r; e.stall = es; e.flush = ef; e.busy = eb; e.preload = pre;
    sb.push_back(e);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, ".stall"}, {26'd0, bus.stall_o}, {26'd0, e.stall});
      chk({e.tag, ".flush"}, {31'd0, bus.flush_o}, {31'd0, e.flush});
      chk({e.tag, ".busy"},  {31'd0, bus.busy_o},  {31'd0, e.busy});
`ifdef PIPE_PERF_CNT_EN
      chk({e.tag, ".cnt"}, stall_cnt_o, exp_cnt);
      if (e.preload) begin
        dut.stall_cnt_q = 32'hFFFF_FFFE;
        exp_cnt = 32'hFFFF_FFFE;
      end
      if (e.rst) exp_cnt = '0;
      else if (e.stall != '0) exp_cnt = exp_cnt + 32'd1;
`endif
    end else if (fin) begin
      chk("sb_drain", 32'(sb.size()), 32'd0);
    end
  end

  localparam logic [5:0] MC = 6'b001111;
  localparam logic [5:0] LU = 6'b000111;
  localparam logic [5:0] NO = 6'b000000;

  initial begin
    rst = 1'b1;
    bus.id_stallreq_i = 1'b0; bus.ex_mc_start_i = 1'b0; bus.ex_mc_cycles_i = '0;
    bus.ex_mc_done_i = 1'b0; bus.flush_i = 1'b0;
    @(posedge clk); #1;

    //   tag        rst sr st cyc    dn fl  stall fl busy
    step("rst0",    1, 0, 0, 6'd0, 0, 0, NO, 0, 0);
    step("rst_in",  1, 1, 1, 6'd5, 1, 1, NO, 0, 0);
    step("idle",    0, 0, 0, 6'd0, 0, 0, NO, 0, 0);

    // five-cycle op; load-use and a second start are masked while waiting
    step("mc5_t0",  0, 0, 1, 6'd5, 0, 0, MC, 0, 0);
    step("mc5_t1",  0, 0, 0, 6'd0, 0, 0, MC, 0, 1);
    step("mc5_t2",  0, 1, 0, 6'd0, 0, 0, MC, 0, 1);
    step("mc5_t3",  0, 0, 1, 6'd3, 0, 0, MC, 0, 1);
    step("mc5_t4",  0, 0, 0, 6'd0, 0, 0, MC, 0, 1);
    step("mc5_t5",  0, 0, 0, 6'd0, 0, 0, NO, 0, 0);

    // load-use for two cycles
    step("lu_t0",   0, 1, 0, 6'd0, 0, 0, LU, 0, 0);
    step("lu_t1",   0, 1, 0, 6'd0, 0, 0, LU, 0, 0);
    step("lu_t2",   0, 0, 0, 6'd0, 0, 0, NO, 0, 0);

    // early completion of a ten-cycle op
    step("ed_t0",   0, 0, 1, 6'd10, 0, 0, MC, 0, 0);
    step("ed_t1",   0, 0, 0, 6'd0, 0, 0, MC, 0, 1);
    step("ed_t2",   0, 0, 0, 6'd0, 0, 0, MC, 0, 1);
    step("ed_t3",   0, 0, 0, 6'd0, 1, 0, NO, 0, 1);
    step("ed_t4",   0, 0, 0, 6'd0, 1, 0, NO, 0, 0);

    // flush outranks start and load-use
    step("fp_t0",   0, 1, 1, 6'd5, 0, 1, NO, 1, 0);
    step("fp_t1",   0, 0, 0, 6'd0, 0, 0, NO, 0, 0);

    // flush aborts an eight-cycle op
    step("fa_t0",   0, 0, 1, 6'd8, 0, 0, MC, 0, 0);
    step("fa_t1",   0, 0, 0, 6'd0, 0, 0, MC, 0, 1);
    step("fa_t2",   0, 0, 0, 6'd0, 1, 1, NO, 1, 1);
    step("fa_t3",   0, 0, 0, 6'd0, 0, 0, NO, 0, 0);

    // cycle-count boundaries
    step("c0_t0",   0, 0, 1, 6'd0, 0, 0, NO, 0, 0);
    step("c0_t1",   0, 0, 0, 6'd0, 0, 0, NO, 0, 0);
    step("c1_t0",   0, 0, 1, 6'd1, 0, 0, MC, 0, 0);
    step("c1_t1",   0, 0, 0, 6'd0, 0, 0, NO, 0, 0);
    step("c2_t0",   0, 0, 1, 6'd2, 0, 0, MC, 0, 0);
    step("c2_t1",   0, 0, 0, 6'd0, 0, 0, MC, 0, 1);
    step("c2_t2",   0, 1, 0, 6'd0, 0, 0, LU, 0, 0);

    // reset in the middle of an eight-cycle op
    step("ra_t0",   0, 0, 1, 6'd8, 0, 0, MC, 0, 0);
    step("ra_t1",   0, 0, 0, 6'd0, 0, 0, MC, 0, 1);
    step("ra_t2",   1, 1, 0, 6'd0, 0, 0, NO, 0, 0);
    step("ra_t3",   0, 0, 0, 6'd0, 0, 0, NO, 0, 0);
    step("ra_t4",   0, 1, 0, 6'd0, 0, 0, LU, 0, 0);

    // stall counting: five-cycle op plus two load-use cycles from reset
    step("pc_rst",  1, 0, 0, 6'd0, 0, 0, NO, 0, 0);
    step("pc_m0",   0, 0, 1, 6'd5, 0, 0, MC, 0, 0);
    for (int i = 0; i < 4; i++)
      step("pc_mw", 0, 0, 0, 6'd0, 0, 0, MC, 0, 1);
    step("pc_lu0",  0, 1, 0, 6'd0, 0, 0, LU, 0, 0);
    step("pc_lu1",  0, 1, 0, 6'd0, 0, 0, LU, 0, 0);
    step("pc_fl",   0, 0, 0, 6'd0, 0, 1, NO, 1, 0);
    step("pc_chk7", 0, 0, 0, 6'd0, 0, 0, NO, 0, 0, 1'b1);

    // wrap after preload near the top
    step("wr_t0",   0, 1, 0, 6'd0, 0, 0, LU, 0, 0);
    step("wr_t1",   0, 1, 0, 6'd0, 0, 0, LU, 0, 0);
    step("wr_t2",   0, 1, 0, 6'd0, 0, 0, LU, 0, 0);
    step("wr_t3",   0, 0, 0, 6'd0, 0, 0, NO, 0, 0);
    step("wr_t4",   0, 0, 0, 6'd0, 0, 0, NO, 0, 0);

    fin = 1'b1;
    @(negedge clk);
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
